// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a
//            2-flop input synchroniser, mid-bit sampling and break handling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Both synchroniser stages reset to the idle (high) level so that reset
    // release can never look like a start bit.
    logic             rx_meta_q;
    logic             rx_s_q;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;
    logic             busy_q,    busy_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             perr_q,    perr_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // Half a bit in: a line that is high again was only a glitch.
            S_START: begin
                if (cnt_q == c_half_last) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s_q;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            // A low stop bit wins over any parity verdict.
            S_STOP: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bit_q != ^shift_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
`else
                        valid_d = 1'b1;
                        data_d  = shift_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Held-low line: report once, then wait for the line to recover.
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx; frame-level reference model, random
//            and directed frames. Honours UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int NOM_LAT = 108;
`else
    localparam int NOM_LAT = 98;
`endif
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic       perr;

    exp_t       exp_q[$];
    exp_t       e_mon;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_events = 0;
    int         kind_seen;
    logic [7:0] model_data = 8'h00;

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(perr)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every output pulse pops one expected frame outcome.
    always @(negedge clk) begin
        if (!reset && (rx_valid || frame_err || perr)) begin
            n_events++;
            check("valid_ferr_exclusive", int'(rx_valid && frame_err), 0);
            kind_seen = rx_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
            if (exp_q.size() == 0) begin
                check("unexpected_event_kind", kind_seen, -1);
            end else begin
                e_mon = exp_q.pop_front();
                check("event_kind", kind_seen, e_mon.kind);
                check("rx_data", int'(rx_data), int'(e_mon.data));
                checks++;
                if ((cyc - e_mon.start) < NOM_LAT - 1 || (cyc - e_mon.start) > NOM_LAT + 1) begin
                    errors++;
                    $display("FAIL latency: got %0d expected %0d +/-1", cyc - e_mon.start, NOM_LAT);
                end
            end
        end
    end

    // Frame-level reference: outcome depends only on stop level and parity.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        exp_t e;
        e.start = cyc;
        if (!stop) begin
            e.kind = K_FERR;
`ifdef UART_RX_PARITY_EN
        end else if (par != ^b) begin
            e.kind = K_PERR;
`endif
        end else begin
            e.kind     = K_VALID;
            model_data = b;
        end
        e.data = model_data;
        exp_q.push_back(e);

        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = par;
        repeat (CPB) @(negedge clk);
`endif
        rx_in = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
    endtask

    initial begin
        int         ev0;
        bit         busy_seen;
        logic [7:0] dirs [4];
        logic [7:0] rb;
        logic       rstop;
        logic       rpar;

        dirs[0] = 8'hF0; dirs[1] = 8'hAA; dirs[2] = 8'h00; dirs[3] = 8'hFF;

        // Reset and idle line
        repeat (5) @(negedge clk);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(rx_valid), 0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_rx_data", int'(rx_data), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_no_events", n_events, 0);

        // Ideal-timing directed frames
        foreach (dirs[i]) begin
            send_frame(dirs[i], ^dirs[i], 1'b1);
            repeat (5) @(negedge clk);
        end
        wait_drain();

        // Back-to-back frames, no idle gap
        send_frame(8'h5A, ^8'h5A, 1'b1);
        send_frame(8'hA5, ^8'hA5, 1'b1);
        wait_drain();

        // Short low glitch
        ev0       = n_events;
        busy_seen = 1'b0;
        rx_in     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) rx_in = 1'b1;
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("glitch_busy_seen", int'(busy_seen), 1);
        repeat (20) @(negedge clk);
        check("glitch_busy_clear", int'(busy), 0);
        check("glitch_no_events", n_events, ev0);

        // Stop bit low, line held low, then recovery
        ev0 = n_events;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        repeat (25) @(negedge clk);
        rx_in = 1'b1;
        wait_drain();
        check("break_single_ferr", n_events, ev0 + 1);
        check("break_data_kept", int'(rx_data), int'(model_data));
        check("break_busy_clear", int'(busy), 0);
        send_frame(8'h81, ^8'h81, 1'b1);
        wait_drain();

        // Reset in the middle of a data phase
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = ((8'hC3 >> i) & 8'h01) != 0;
            repeat (CPB) @(negedge clk);
        end
        reset = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check("midreset_rx_data", int'(rx_data), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(rx_valid || frame_err), 0);
        repeat (4) @(negedge clk);
        reset      = 1'b0;
        model_data = 8'h00;
        repeat (20) @(negedge clk);
        send_frame(8'h7E, ^8'h7E, 1'b1);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_drain();
`endif

        // Randomised frames, occasional bad stop and bad parity
        for (int n = 0; n < 12; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rpar  = ^rb ^ ($urandom_range(0, 4) == 0);
            send_frame(rb, rpar, rstop);
            rx_in = 1'b1;
            repeat (rstop ? $urandom_range(0, 15) : $urandom_range(12, 20)) @(negedge clk);
        end
        wait_drain();
        check("final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
